// File: rtl/alu_pkg.sv
// Shared encodings and widths for the two-requester ALU scheduler.
// Operands are 4-bit, results 8-bit; the cycle counter covers 1..15.
package alu_pkg;

   localparam int OPND_W = 4;
   localparam int RES_W  = 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic [RES_W-1:0] zext(input logic [OPND_W-1:0] v);
      return {{(RES_W-OPND_W){1'b0}}, v};
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4x4 -> 8 ALU: add, sub (mod 256), mul, xor.
module alu_core
   import alu_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  op_e               sel,
   output logic [RES_W-1:0]  z
);

   always_comb begin
      z = '0;
      case (sel)
         OP_ADD:  z = zext(a) + zext(b);
         OP_SUB:  z = zext(a) - zext(b);
         OP_MUL:  z = zext(a) * zext(b);
         OP_XOR:  z = zext(a ^ b);
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler feeding one shared ALU; one operation in flight,
// fixed latency, result held until the consumer takes it.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int MUL_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [OPND_W-1:0] req_a0,
   input  logic [OPND_W-1:0] req_b0,
   input  logic [1:0]        req_sel0,
   input  logic [OPND_W-1:0] req_a1,
   input  logic [OPND_W-1:0] req_b1,
   input  logic [1:0]        req_sel1,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [RES_W-1:0]  rsp_z,
   output logic              busy
);

   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   state_e             state;
   logic               last;
   logic [CNT_W-1:0]   cnt;
   logic [OPND_W-1:0]  a_q;
   logic [OPND_W-1:0]  b_q;
   op_e                op_q;
   logic               id_q;
   logic [1:0]         grant;
   logic               gid;
   op_e                op_in;
   logic [RES_W-1:0]   z_c;

   // Grant is combinational and only offered in IDLE; the requester not
   // served last wins a tie.
   always_comb begin
      grant = 2'b00;
      if (rst_n && state == ST_IDLE) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign gid       = grant[1];
   assign op_in     = op_e'(gid ? req_sel1 : req_sel0);

   alu_core u_core (
      .a   (a_q),
      .b   (b_q),
      .sel (op_q),
      .z   (z_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_z     <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            // accept: capture operands of the granted requester
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  a_q   <= gid ? req_a1 : req_a0;
                  b_q   <= gid ? req_b1 : req_b0;
                  op_q  <= op_in;
                  id_q  <= gid;
                  cnt   <= (op_in == OP_MUL) ? MUL_CNT : ONE_CNT;
                  busy  <= 1'b1;
                  state <= ST_EXEC;
               end
            end
            // execute: count down, register the result once the count is spent
            ST_EXEC: begin
               if (cnt == '0) begin
                  rsp_z     <= z_c;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt - ONE_CNT;
               end
            end
            // respond: hold until taken, then remember who was served
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  last      <= rsp_id;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// Cycle-stepped bench for alu_scheduler: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_alu_scheduler;

   localparam int M = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [3:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0] req_sel0, req_sel1;
   logic       rsp_valid, rsp_ready, rsp_id, busy;
   logic [7:0] rsp_z;

   always #5 clk = ~clk;

   alu_scheduler #(.MUL_CYCLES(M)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_sel0  (req_sel0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_sel1  (req_sel1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_z     (rsp_z),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: transaction state plus cycles left until the response
   bit         m_busy = 0, m_resp = 0, m_id = 0, m_pid = 0, m_last = 1;
   int         m_left = 0;
   logic [7:0] m_z = 0, m_pz = 0;
   int         acc_ids[$];
   int         acc_cnt[2];
   int         rsp_cnt[2];
   int         last_acc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_alu(input int a, input int b, input int s);
      case (s)
         0:       return 8'((a + b) % 256);
         1:       return 8'((a - b + 256) % 256);
         2:       return 8'((a * b) % 256);
         default: return 8'(a ^ b);
      endcase
   endfunction

   function automatic logic [1:0] exp_ready(input logic r, input logic [1:0] v);
      if (!r || m_busy) return 2'b00;
      if (v == 2'b11)   return m_last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // one clock: drive, check the combinational grant, take the edge, check outputs
   task automatic step(input logic r, input logic [1:0] v,
                       input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] s0,
                       input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] s1,
                       input logic rr);
      logic [1:0] er;
      int         ga, gb, gs;
      rst_n = r; req_valid = v; rsp_ready = rr;
      req_a0 = a0; req_b0 = b0; req_sel0 = s0;
      req_a1 = a1; req_b1 = b1; req_sel1 = s1;
      last_acc = -1;
      #1;
      er = exp_ready(r, v);
      chk("req_ready", 32'(req_ready), 32'(er));
      @(posedge clk);
      #1;
      if (!r) begin
         m_busy = 0; m_resp = 0; m_left = 0; m_z = 0; m_id = 0; m_last = 1;
      end else if (!m_busy) begin
         if (er != 2'b00) begin
            ga = er[1] ? int'(a1) : int'(a0);
            gb = er[1] ? int'(b1) : int'(b0);
            gs = er[1] ? int'(s1) : int'(s0);
            m_pz   = ref_alu(ga, gb, gs);
            m_pid  = er[1];
            m_left = (gs == 2) ? M + 1 : 2;
            m_busy = 1;
            last_acc = int'(er[1]);
            acc_ids.push_back(last_acc);
            acc_cnt[last_acc]++;
         end
      end else if (!m_resp) begin
         m_left--;
         if (m_left == 0) begin
            m_resp = 1; m_z = m_pz; m_id = m_pid;
         end
      end else if (rr) begin
         rsp_cnt[m_id]++;
         m_resp = 0; m_busy = 0; m_last = m_id;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("rsp_z",     32'(rsp_z),     32'(m_z));
      chk("rsp_id",    32'(rsp_id),    32'(m_id));
   endtask

   task automatic idle(input logic rr);
      step(1'b1, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 2'b00, rr);
   endtask

   initial begin
      int a0_, b0_, c0_[2], c1_[2];
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
      req_a0 = 0; req_b0 = 0; req_sel0 = 0; req_a1 = 0; req_b1 = 0; req_sel1 = 0;
      @(posedge clk);
      #1;

      // reset, with requests pending: nothing granted, outputs clear
      for (int i = 0; i < 3; i++)
         step(1'b0, 2'b11, 4'h1, 4'h2, 2'b00, 4'h3, 4'h4, 2'b00, 1'b1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_z", 32'(rsp_z), 32'd0);

      // add from requester 0, result two cycles after acceptance
      step(1'b1, 2'b01, 4'h9, 4'h8, 2'b00, 4'h0, 4'h0, 2'b00, 1'b1);
      chk("add_grant", 32'(last_acc), 32'd0);
      idle(1'b1);
      chk("add_lat1", 32'(rsp_valid), 32'd0);
      idle(1'b1);
      chk("add_valid", 32'(rsp_valid), 32'd1);
      chk("add_z", 32'(rsp_z), 32'h11);
      chk("add_id", 32'(rsp_id), 32'd0);
      idle(1'b1);

      // sub from requester 1
      step(1'b1, 2'b10, 4'h0, 4'h0, 2'b00, 4'h3, 4'h5, 2'b01, 1'b1);
      chk("sub_grant", 32'(last_acc), 32'd1);
      idle(1'b1); idle(1'b1);
      chk("sub_z", 32'(rsp_z), 32'hFE);
      chk("sub_id", 32'(rsp_id), 32'd1);
      idle(1'b1);

      // xor from requester 0
      step(1'b1, 2'b01, 4'hA, 4'h6, 2'b11, 4'h0, 4'h0, 2'b00, 1'b1);
      idle(1'b1); idle(1'b1);
      chk("xor_z", 32'(rsp_z), 32'h0C);
      idle(1'b1);

      // mul, then hold the response under back-pressure
      step(1'b1, 2'b01, 4'hF, 4'hF, 2'b10, 4'h0, 4'h0, 2'b00, 1'b0);
      idle(1'b0);
      chk("mul_busy1", 32'(busy), 32'd1);
      idle(1'b0);
      chk("mul_busy2", 32'(busy), 32'd1);
      chk("mul_lat2", 32'(rsp_valid), 32'd0);
      idle(1'b0);
      chk("mul_valid", 32'(rsp_valid), 32'd1);
      chk("mul_z", 32'(rsp_z), 32'hE1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 2'b11, 4'h1, 4'h1, 2'b00, 4'h2, 4'h2, 2'b00, 1'b0);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_z", 32'(rsp_z), 32'hE1);
      end
      idle(1'b1);
      chk("bp_release", 32'(busy), 32'd0);

      // reset in the middle of a mul: no response, requester 0 wins next
      step(1'b1, 2'b10, 4'h0, 4'h0, 2'b00, 4'h7, 4'h7, 2'b10, 1'b1);
      idle(1'b1);
      step(1'b0, 2'b00, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 2'b00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      step(1'b1, 2'b11, 4'h2, 4'h3, 2'b00, 4'h4, 4'h5, 2'b00, 1'b1);
      chk("rst_next_grant", 32'(last_acc), 32'd0);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // both requesters always valid: grants alternate, one response each
      acc_ids.delete();
      c0_ = acc_cnt; c1_ = rsp_cnt;
      for (int i = 0; i < 30; i++)
         step(1'b1, 2'b11, 4'($urandom), 4'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);
      chk("arb_count", 32'(acc_ids.size() >= 6), 32'd1);
      for (int i = 1; i < acc_ids.size(); i++)
         chk("arb_alt", 32'(acc_ids[i]), 32'(1 - acc_ids[i-1]));
      for (int k = 0; k < 2; k++)
         chk("arb_rsp", 32'(rsp_cnt[k] - c1_[k]), 32'(acc_cnt[k] - c0_[k]));

      // random traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         a0_ = ($urandom_range(0, 59) != 0) ? 1 : 0;
         b0_ = ($urandom_range(0, 3) != 0) ? 1 : 0;
         step(1'(a0_), 2'($urandom_range(0, 3)),
              4'($urandom), 4'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom), 2'($urandom), 1'(b0_));
      end
      for (int i = 0; i < 6; i++) idle(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter MUL_CYCLES, default 2, meaning: EXEC cycles for a multiply (legal range 1-15).
REQ-002 Port clk  input  1  single rising-edge clock for all state.
REQ-003 Port rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Ports req_valid  input  2, and req_ready  output  2: per-requester handshake, index 0 or 1.
REQ-005 Ports req_a0, req_b0  input  4 each, and req_sel0  input  2: requester 0 operands and op.
REQ-006 Ports req_a1, req_b1  input  4 each, and req_sel1  input  2: requester 1 operands and op.
REQ-007 Ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 and rsp_z  output  8: result handshake.
REQ-008 Port busy  output  1, high whenever state is not IDLE.

Function
REQ-009 Op encoding SHALL be: 00 add, 01 sub, 10 mul, 11 xor.
REQ-010 Add SHALL zero-extend a+b to 8 bits; sub SHALL be (a-b) modulo 256 (3-5 = 8'hFE); mul SHALL be the 8-bit product; xor SHALL be {4'h0, a^b}.
REQ-011 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-012 IDLE: if any req_valid is high, the scheduler SHALL assert exactly one req_ready bit combinationally, for the granted requester.
REQ-013 Grant SHALL be round-robin: when both are valid, the requester not granted last wins; after reset, requester 0 has priority.
REQ-014 On req_valid&req_ready, the scheduler SHALL latch a, b, op and id, load the cycle counter (MUL_CYCLES for mul, 1 otherwise), and move to EXEC.
REQ-015 EXEC: the counter SHALL decrement each cycle; in the cycle it reaches 0, rsp_z and rsp_id SHALL be registered, and the FSM SHALL move to RESP.
REQ-016 RESP: rsp_valid SHALL be high, and rsp_z/rsp_id SHALL be stable until rsp_ready is sampled high; the FSM then returns to IDLE and updates the last-grant pointer.
REQ-017 Latency SHALL be fixed: non-mul rsp_valid rises 2 cycles after the accept edge; mul rises MUL_CYCLES+1 cycles after it.
REQ-018 req_ready SHALL be 0 in EXEC and RESP, so at most one operation is outstanding.
REQ-019 A request dropped before acceptance SHALL NOT be granted; req_valid does not have to be held.
REQ-020 Grant SHALL take effect only in IDLE; rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-021 When rst_n=0 at a clk edge, state SHALL be IDLE and the last-grant pointer SHALL be 1, so requester 0 wins first.
REQ-022 The same reset SHALL clear rsp_valid, rsp_id, rsp_z, busy, req_ready and the counter to 0.
REQ-023 Reset during EXEC or RESP SHALL discard the operation in flight, and no response SHALL be produced.

Structure
REQ-024 Op encodings, FSM state encodings and the result width (8) SHALL live in the shared package alu_pkg.
REQ-025 Arithmetic SHALL be a purely combinational sub-module alu_core (a, b, sel -> z), instantiated once; the scheduler holds all sequential state.

Verification
REQ-026 Add: after reset, requester 0 sends a=4'h9, b=4'h8, sel=00, with rsp_ready tied high -> rsp_z=8'h11 and rsp_id=0, with rsp_valid high 2 cycles after the accept edge.
REQ-027 Sub and xor: sub with a=3, b=5 -> rsp_z=8'hFE; xor with a=4'hA, b=4'h6 -> rsp_z=8'h0C.
REQ-028 Mul with MUL_CYCLES=2: a=4'hF, b=4'hF -> rsp_z=8'hE1, valid 3 cycles after the accept edge, and busy high throughout.
REQ-029 Arbitration: both requesters valid continuously -> grants alternate 0,1,0,1 and each gets exactly one response per grant.
REQ-030 Back-pressure: rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_z stable, req_ready stays 0; reset asserted mid-EXEC -> no rsp_valid follows, and the next grant goes to requester 0.
